// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Target end of the core's load/store interface. A single request is taken
// over a valid/ready handshake, held for LATENCY cycles, and then answered
// over a second valid/ready handshake. The core can then be tested against a
// data memory whose latency is not fixed.
//
// Ports
//   clk           in   1         clock, rising edge
//   rst           in   1         asynchronous reset, active-high
//   req_vld_i     in   1         request valid
//   req_rdy_o     out  1         request ready (high only in IDLE, outside reset)
//   addr_i        in   AWIDTH    byte address; bits below the word size are ignored
//   data_i        in   DWIDTH    write data, lane-aligned by the initiator
//   write_strb_i  in   DWIDTH/8  byte enables for writes
//   write_en_i    in   1         1 = write, 0 = read
//   rsp_vld_o     out  1         response valid
//   rsp_rdy_i     in   1         response ready
//   data_o        out  DWIDTH    read data (0 for writes and errors)
//   err_o         out  1         address outside [BASE_ADDR, BASE_ADDR+DEPTH_BYTES)
//
// Latency: if the request is accepted on edge N, the response can first hand
// off on edge N+LATENCY. This means rsp_vld_o rises right after edge
// N+LATENCY-1.
// ---------------------------------------------------------------------------
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif

module dmem_responder #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH_BYTES = `MEM_DEPTH,
    parameter int                LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_vld_i,
    output logic                req_rdy_o,
    input  logic [AWIDTH-1:0]   addr_i,
    input  logic [DWIDTH-1:0]   data_i,
    input  logic [DWIDTH/8-1:0] write_strb_i,
    input  logic                write_en_i,
    output logic                rsp_vld_o,
    input  logic                rsp_rdy_i,
    output logic [DWIDTH-1:0]   data_o,
    output logic                err_o
);

    localparam int STRB_W      = DWIDTH / 8;
    localparam int DEPTH_WORDS = DEPTH_BYTES / STRB_W;
    localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int OFF_SHIFT   = $clog2(STRB_W);

    localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH_BYTES);
    localparam logic [3:0]        LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [DWIDTH-1:0]   rspData_q;
    logic                rspErr_q;

    logic [DWIDTH-1:0]   mem [DEPTH_WORDS];

    logic [AWIDTH-1:0]   offset;
    logic                inRange;
    logic [IDX_W-1:0]    wordIdx;
    logic [DWIDTH-1:0]   readWord;
    logic                accept;

    // Parameter checks at elaboration. The down-counter is 4 bits wide, so
    // LATENCY cannot be larger than 15. The storage decode depends on the depth
    // being a power of two made of whole words.
    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : gBadDepthPow2
        $error("dmem_responder: DEPTH_BYTES must be a power of two");
    end
    if ((DEPTH_BYTES % STRB_W) != 0) begin : gBadDepthWords
        $error("dmem_responder: DEPTH_BYTES must be a multiple of DWIDTH/8");
    end

    // Address decode. The subtraction is unsigned, so an address below the base
    // wraps to a large offset. The explicit lower-bound compare is still kept so
    // that the range test is clear to a reader.
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        inRange  = (addr_i >= BASE_ADDR) && (offset < DEPTH_A);
        wordIdx  = offset[OFF_SHIFT +: IDX_W];
        readWord = mem[wordIdx];
    end

    // Ready is held low for the whole time reset is asserted. As a result no
    // write can reach storage while the block is in reset.
    assign req_rdy_o = (state_q == IDLE) && !rst;
    assign accept    = req_vld_i && req_rdy_o;

    // Next-state logic. With LATENCY==1 the request goes straight to RESP.
    // Otherwise it waits in WAIT while the counter runs down from LATENCY-1.
    // The FSM leaves WAIT on the edge where the counter steps from 1 to 0.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and response capture. The response payload is fixed on
    // the accept edge. A read therefore returns the word as it was at accept
    // time, and the payload stays stable through any back-pressure in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                rspData_q <= (write_en_i || !inRange) ? '0 : readWord;
                rspErr_q  <= !inRange;
            end
        end
    end

    // Storage write port. Reset does not clear storage, so this block has no
    // reset. A write is committed on the accept edge, one byte lane at a time,
    // and only for lanes with the strobe set. An out-of-range write is dropped
    // so that it cannot alias onto a real word.
    always_ff @(posedge clk) begin
        if (accept && write_en_i && inRange) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (write_strb_i[b]) begin
                    mem[wordIdx][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    assign rsp_vld_o = (state_q == RESP);
    assign data_o    = rspData_q;
    assign err_o     = rspErr_q;

    // The handshake outputs must be driven to known values whenever the block
    // is out of reset.
    noXOnHandshake: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(rsp_vld_o) && !$isunknown(req_rdy_o));

endmodule
